id_stage: RTL and testbench

- Instruction-decode stage of the 16-bit 5-stage MIPS pipeline, sitting directly upstream of register_file reads and feeding EX.
- Decodes the IF/ID instruction and drives the two register_file read addresses.
- Bypasses same-cycle write-back data and detects load-use hazards (stall) and branch flushes (bubble).
- Registers everything into the ID/EX pipeline register.

---
 rtl/mips16_pkg.sv | 39 +++
 rtl/id_decoder.sv | 73 +++++++
 rtl/id_stage.sv | 174 +++++++++++++++++
 tb/tb_id_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// Shared definitions for the 16-bit MIPS pipeline: widths, opcodes, ALU ops
// and the ID/EX control bundle.
package mips16_pkg;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int IMM_W = 6;

    localparam logic [3:0] OP_RTYPE = 4'd0;
    localparam logic [3:0] OP_ADDI  = 4'd1;
    localparam logic [3:0] OP_ANDI  = 4'd2;
    localparam logic [3:0] OP_LW    = 4'd3;
    localparam logic [3:0] OP_SW    = 4'd4;
    localparam logic [3:0] OP_BEQ   = 4'd5;
    localparam logic [3:0] OP_BNE   = 4'd6;
    localparam logic [3:0] OP_J     = 4'd7;

    // R-type funct values map directly onto these encodings.
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_NOR = 3'd5;
    localparam logic [2:0] ALU_SLT = 3'd6;
    localparam logic [2:0] ALU_SLL = 3'd7;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] alu_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decoder: instruction word to control bundle,
// destination register, extended immediate and source-usage flags.
module id_decoder
    import mips16_pkg::*;
#(
    parameter int DW    = mips16_pkg::DW,
    parameter int AW    = mips16_pkg::AW,
    parameter int IMM_W = mips16_pkg::IMM_W
) (
    input  logic [DW-1:0] instr,
    output ctrl_t         ctrl,
    output logic [AW-1:0] dst,
    output logic [DW-1:0] imm,
    output logic          rs_used,
    output logic          rt_used
);

    logic [3:0] op;

    assign op = instr[15:12];

    always_comb begin
        ctrl    = '0;
        dst     = '0;
        imm     = {{(DW-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
        rs_used = (op != OP_J);
        rt_used = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = instr[2:0];
                dst            = instr[5:3];
                rt_used        = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                dst            = instr[8:6];
            end
            OP_ANDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_AND;
                dst            = instr[8:6];
            end
            OP_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                dst            = instr[8:6];
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                rt_used        = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
                rt_used     = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
                imm       = {{(DW-12){1'b0}}, instr[11:0]};
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: register-file addressing, write-back bypass,
// load-use stall, flush bubbles and the ID/EX pipeline register.
// Optional bubble counter enabled by defining ID_STALL_COUNT_EN.
module id_stage
    import mips16_pkg::*;
#(
    parameter int DW    = mips16_pkg::DW,
    parameter int AW    = mips16_pkg::AW,
    parameter int IMM_W = mips16_pkg::IMM_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] if_instr,
    input  logic [DW-1:0] if_pc,
    input  logic          if_valid,
    output logic [AW-1:0] rf_rd1_addr,
    output logic [AW-1:0] rf_rd2_addr,
    input  logic [DW-1:0] rf_rd1_data,
    input  logic [DW-1:0] rf_rd2_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic          flush,
    output logic          stall,
    output logic          ex_valid,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_alu_src,
    output logic          ex_branch,
    output logic          ex_jump,
    output logic [2:0]    ex_alu_op,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [AW-1:0] ex_rs,
    output logic [AW-1:0] ex_rt,
    output logic [AW-1:0] ex_dst,
    output logic [DW-1:0] ex_pc,
`ifdef ID_STALL_COUNT_EN
    output logic [15:0]   bubble_cnt,
`endif
    output logic          ex_illegal
);

    ctrl_t         dec_ctrl;
    logic [AW-1:0] dec_dst;
    logic [DW-1:0] dec_imm;
    logic          rs_used;
    logic          rt_used;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          bubble;

    logic          valid_d,   valid_q;
    ctrl_t         ctrl_d,    ctrl_q;
    logic [DW-1:0] rs_data_d, rs_data_q;
    logic [DW-1:0] rt_data_d, rt_data_q;
    logic [DW-1:0] imm_d,     imm_q;
    logic [AW-1:0] rs_d,      rs_q;
    logic [AW-1:0] rt_d,      rt_q;
    logic [AW-1:0] dst_d,     dst_q;
    logic [DW-1:0] pc_d,      pc_q;

    id_decoder #(.DW(DW), .AW(AW), .IMM_W(IMM_W)) u_dec (
        .instr   (if_instr),
        .ctrl    (dec_ctrl),
        .dst     (dec_dst),
        .imm     (dec_imm),
        .rs_used (rs_used),
        .rt_used (rt_used)
    );

    assign rs          = if_instr[11:9];
    assign rt          = if_instr[8:6];
    assign rf_rd1_addr = rs;
    assign rf_rd2_addr = rt;

    // The register file commits on the edge, so a same-cycle read is stale.
    assign op1 = (wb_we && (wb_addr == rs)) ? wb_data : rf_rd1_data;
    assign op2 = (wb_we && (wb_addr == rt)) ? wb_data : rf_rd2_data;

    assign stall  = if_valid && valid_q && ctrl_q.mem_read &&
                    ((rs_used && (rt_q == rs)) || (rt_used && (rt_q == rt)));
    assign bubble = flush || stall;

    always_comb begin
        valid_d   = if_valid;
        ctrl_d    = if_valid ? dec_ctrl : '0;
        rs_data_d = op1;
        rt_data_d = op2;
        imm_d     = dec_imm;
        rs_d      = rs;
        rt_d      = rt;
        dst_d     = dec_dst;
        pc_d      = if_pc;
        if (bubble) begin
            valid_d   = 1'b0;
            ctrl_d    = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_d      = '0;
            rt_d      = '0;
            dst_d     = '0;
            pc_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dst_q     <= '0;
            pc_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            dst_q     <= dst_d;
            pc_q      <= pc_d;
        end
    end

`ifdef ID_STALL_COUNT_EN
    logic [15:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`endif

    assign ex_valid     = valid_q;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_alu_src   = ctrl_q.alu_src;
    assign ex_branch    = ctrl_q.branch;
    assign ex_jump      = ctrl_q.jump;
    assign ex_alu_op    = ctrl_q.alu_op;
    assign ex_illegal   = ctrl_q.illegal;
    assign ex_rs_data   = rs_data_q;
    assign ex_rt_data   = rt_data_q;
    assign ex_imm       = imm_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_dst       = dst_q;
    assign ex_pc        = pc_q;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: expected ID/EX contents are queued as each
// instruction is presented and compared after the capturing edge.
module tb_id_stage;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic [2:0]  alu_op;
        logic        illegal;
        logic [15:0] rs_data;
        logic [15:0] rt_data;
        logic [15:0] imm;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  dst;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] if_instr, if_pc;
    logic        if_valid;
    logic [2:0]  rf_rd1_addr, rf_rd2_addr;
    logic [15:0] rf_rd1_data, rf_rd2_data;
    logic        wb_we;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;
    logic        stall;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        ex_alu_src, ex_branch, ex_jump, ex_illegal;
    logic [2:0]  ex_alu_op, ex_rs, ex_rt, ex_dst;
    logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
`ifdef ID_STALL_COUNT_EN
    logic [15:0] bubble_cnt;
    logic [15:0] exp_cnt;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    exp_t last_exp;

    always #5 clk = ~clk;

    id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_valid     (if_valid),
        .rf_rd1_addr  (rf_rd1_addr),
        .rf_rd2_addr  (rf_rd2_addr),
        .rf_rd1_data  (rf_rd1_data),
        .rf_rd2_data  (rf_rd2_data),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .flush        (flush),
        .stall        (stall),
        .ex_valid     (ex_valid),
        .ex_reg_write (ex_reg_write),
        .ex_mem_read  (ex_mem_read),
        .ex_mem_write (ex_mem_write),
        .ex_alu_src   (ex_alu_src),
        .ex_branch    (ex_branch),
        .ex_jump      (ex_jump),
        .ex_alu_op    (ex_alu_op),
        .ex_rs_data   (ex_rs_data),
        .ex_rt_data   (ex_rt_data),
        .ex_imm       (ex_imm),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_dst       (ex_dst),
        .ex_pc        (ex_pc),
`ifdef ID_STALL_COUNT_EN
        .bubble_cnt   (bubble_cnt),
`endif
        .ex_illegal   (ex_illegal)
    );

    function automatic logic [15:0] mk_i(input int op, input int rs, input int rt, input int low6);
        mk_i = 16'((op << 12) | (rs << 9) | (rt << 6) | (low6 & 6'h3F));
    endfunction

    // Reference decode written from the instruction-set table.
    function automatic exp_t model(input logic [15:0] ins, input logic [15:0] pc, input logic v,
                                   input logic [15:0] d1, input logic [15:0] d2, input logic we,
                                   input logic [2:0] wa, input logic [15:0] wd);
        exp_t e;
        int   op;
        e       = '0;
        op      = int'(ins[15:12]);
        e.valid = v;
        e.rs    = ins[11:9];
        e.rt    = ins[8:6];
        e.pc    = pc;
        e.rs_data = (we && wa == ins[11:9]) ? wd : d1;
        e.rt_data = (we && wa == ins[8:6])  ? wd : d2;
        e.imm   = ins[5] ? (16'hFFC0 | 16'(ins[5:0])) : 16'(ins[5:0]);
        case (op)
            0: begin e.reg_write = 1; e.alu_op = ins[2:0]; e.dst = ins[5:3]; end
            1: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'd0; e.dst = ins[8:6]; end
            2: begin e.reg_write = 1; e.alu_src = 1; e.alu_op = 3'd2; e.dst = ins[8:6]; end
            3: begin e.reg_write = 1; e.mem_read = 1; e.alu_src = 1; e.dst = ins[8:6]; end
            4: begin e.mem_write = 1; e.alu_src = 1; end
            5, 6: begin e.branch = 1; e.alu_op = 3'd1; end
            7: begin e.jump = 1; e.imm = {4'h0, ins[11:0]}; end
            default: e.illegal = 1;
        endcase
        if (!v) begin
            e.reg_write = 0; e.mem_read = 0; e.mem_write = 0; e.alu_src = 0;
            e.branch = 0; e.jump = 0; e.alu_op = 0; e.illegal = 0;
        end
        return e;
    endfunction

    function automatic logic exp_stall(input logic [15:0] ins, input logic v, input exp_t prev);
        logic rs_u, rt_u;
        int   op;
        op   = int'(ins[15:12]);
        rs_u = (op != 7);
        rt_u = (op == 0) || (op == 4) || (op == 5) || (op == 6);
        return v && prev.valid && prev.mem_read &&
               ((rs_u && prev.rt == ins[11:9]) || (rt_u && prev.rt == ins[8:6]));
    endfunction

    // One instruction slot: drive, check stall, queue expectation, clock, pop and compare.
    task automatic step(input string name, input logic r, input logic [15:0] ins, input logic [15:0] pc,
                        input logic v, input logic [15:0] d1, input logic [15:0] d2, input logic we,
                        input logic [2:0] wa, input logic [15:0] wd, input logic fl);
        exp_t e, got;
        logic es;
        rst = r; if_instr = ins; if_pc = pc; if_valid = v;
        rf_rd1_data = d1; rf_rd2_data = d2; wb_we = we; wb_addr = wa; wb_data = wd; flush = fl;
        #1;
        es = exp_stall(ins, v, last_exp);
        n_cmp++;
        if (stall !== es) begin
            n_err++;
            $display("FAIL %s stall: got %b expected %b", name, stall, es);
        end
        if (!r || fl || es) e = '0;
        else                e = model(ins, pc, v, d1, d2, we, wa, wd);
        sb_q.push_back(e);
`ifdef ID_STALL_COUNT_EN
        if (!r)                             exp_cnt = 16'h0;
        else if ((fl || es) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
`endif
        @(posedge clk);
        #1;
        got = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch, ex_jump,
               ex_alu_op, ex_illegal, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_dst, ex_pc};
        if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s ex_bundle: got %h expected %h", name, got, e);
            end
            last_exp = e;
        end
`ifdef ID_STALL_COUNT_EN
        n_cmp++;
        if (bubble_cnt !== exp_cnt) begin
            n_err++;
            $display("FAIL %s bubble_cnt: got %h expected %h", name, bubble_cnt, exp_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        step("reset0", 0, 16'h1245, 16'h0010, 1, 16'h0, 16'h0, 0, 3'd0, 16'h0, 0);
        step("reset1", 0, 16'h1245, 16'h0010, 1, 16'h0, 16'h0, 0, 3'd0, 16'h0, 0);
        step("addi_after_reset", 1, mk_i(1, 1, 2, 5), 16'h0020, 1, 16'h0007, 16'h0009, 0, 3'd0, 16'h0, 0);
        n_cmp++;
        if (ex_alu_src !== 1'b1 || ex_dst !== 3'd2 || ex_imm !== 16'h0005) begin
            n_err++;
            $display("FAIL addi_fields: got src=%b dst=%0d imm=%h expected 1 2 0005", ex_alu_src, ex_dst, ex_imm);
        end
    endtask

    task automatic test_sign_ext();
        step("signext", 1, mk_i(1, 1, 2, 6'h3E), 16'h0022, 1, 16'h0, 16'h0, 0, 3'd0, 16'h0, 0);
        n_cmp++;
        if (ex_imm !== 16'hFFFE) begin
            n_err++;
            $display("FAIL signext_imm: got %h expected FFFE", ex_imm);
        end
        step("jump_zext", 1, 16'h7ABC, 16'h0024, 1, 16'h0, 16'h0, 0, 3'd0, 16'h0, 0);
    endtask

    task automatic test_bypass();
        step("bypass_on", 1, mk_i(0, 3, 4, 6'o20), 16'h0030, 1, 16'h1111, 16'h2222, 1, 3'd3, 16'hA334, 0);
        n_cmp++;
        if (ex_rs_data !== 16'hA334) begin
            n_err++;
            $display("FAIL bypass_rs: got %h expected A334", ex_rs_data);
        end
        step("bypass_off", 1, mk_i(0, 3, 4, 6'o20), 16'h0032, 1, 16'h1111, 16'h2222, 0, 3'd3, 16'hA334, 0);
        n_cmp++;
        if (ex_rs_data !== 16'h1111) begin
            n_err++;
            $display("FAIL nobypass_rs: got %h expected 1111", ex_rs_data);
        end
        step("bypass_rt", 1, mk_i(4, 1, 5, 2), 16'h0034, 1, 16'h0101, 16'h0202, 1, 3'd5, 16'h5A5A, 0);
    endtask

    task automatic test_load_use();
        step("lw", 1, mk_i(3, 1, 2, 4), 16'h0040, 1, 16'h0100, 16'h0, 0, 3'd0, 16'h0, 0);
        step("use_stall", 1, mk_i(0, 2, 3, 6'o42), 16'h0042, 1, 16'h0, 16'h0033, 0, 3'd0, 16'h0, 0);
        n_cmp++;
        if (ex_valid !== 1'b0) begin
            n_err++;
            $display("FAIL load_use_bubble: got ex_valid=%b expected 0", ex_valid);
        end
        step("use_go", 1, mk_i(0, 2, 3, 6'o42), 16'h0042, 1, 16'h0, 16'h0033, 0, 3'd0, 16'h0, 0);
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_pc !== 16'h0042) begin
            n_err++;
            $display("FAIL load_use_release: got valid=%b pc=%h expected 1 0042", ex_valid, ex_pc);
        end
        step("lw_inv", 1, mk_i(3, 1, 2, 4), 16'h0044, 1, 16'h0, 16'h0, 0, 3'd0, 16'h0, 0);
        step("no_stall_invalid", 1, mk_i(0, 2, 2, 0), 16'h0046, 0, 16'h0, 16'h0, 0, 3'd0, 16'h0, 0);
    endtask

    task automatic test_flush_priority();
        step("lw_f", 1, mk_i(3, 0, 6, 1), 16'h0050, 1, 16'h0, 16'h0, 0, 3'd0, 16'h0, 0);
        step("flush_stall", 1, mk_i(5, 6, 1, 3), 16'h0052, 1, 16'h0, 16'h0, 0, 3'd0, 16'h0, 1);
        step("flush_only", 1, mk_i(2, 1, 1, 7), 16'h0054, 1, 16'h0, 16'h0, 0, 3'd0, 16'h0, 1);
    endtask

    task automatic test_illegal();
        step("illegal", 1, 16'hA123, 16'h0060, 1, 16'h0BAD, 16'h0CAB, 0, 3'd0, 16'h0, 0);
        n_cmp++;
        if (ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || ex_valid !== 1'b1) begin
            n_err++;
            $display("FAIL illegal_ctrl: got ill=%b rw=%b mw=%b v=%b expected 1 0 0 1",
                     ex_illegal, ex_reg_write, ex_mem_write, ex_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        step("lw_r", 1, mk_i(3, 1, 4, 0), 16'h0070, 1, 16'h0, 16'h0, 0, 3'd0, 16'h0, 0);
        step("rst_in_stall", 0, mk_i(0, 4, 1, 0), 16'h0072, 1, 16'h0, 16'h0, 0, 3'd0, 16'h0, 0);
        step("after_rst", 1, mk_i(0, 4, 1, 0), 16'h0072, 1, 16'h0004, 16'h0001, 0, 3'd0, 16'h0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            step("random", 1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0),
                 16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom),
                 1'($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        last_exp = '0;
`ifdef ID_STALL_COUNT_EN
        exp_cnt = 16'h0;
`endif
        rst = 0; if_instr = 16'h0; if_pc = 16'h0; if_valid = 0;
        rf_rd1_data = 16'h0; rf_rd2_data = 16'h0; wb_we = 0; wb_addr = 3'd0; wb_data = 16'h0; flush = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_sign_ext();
        test_bypass();
        test_load_use();
        test_flush_priority();
        test_illegal();
        test_reset_mid_stall();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
